// File: rtl/data_memory_responder.sv
// ============================================================================
// Module   : data_memory_responder
// Brief    : Load/store slave for the pipeline memory stage; RISC-V byte/half/
//            word access with a registered, wait-stated response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_memory_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    write_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [2:0]              f3_q;
    logic [31:0]             mem_q [2**ADDR_WIDTH];

    logic                    w_accept;
    logic                    w_legal;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [31:0]             w_word;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load;
    logic [3:0]              w_be;
    logic [31:0]             w_wlane;
    logic                    w_mem_we;
    logic                    w_unused_addr;

    // Upper address bits alias onto the array and are deliberately dropped.
    assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready  = rst && (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
    assign w_accept   = req_valid && req_ready;

    assign w_idx  = addr_q[ADDR_WIDTH+1:2];
    assign w_word = mem_q[w_idx];
    assign w_half = addr_q[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (addr_q[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        w_load  = 32'd0;
        w_be    = 4'b0000;
        w_wlane = wdata_q;
        case (f3_q)
            3'b000: begin
                w_legal = 1'b1;
                w_load  = {{24{w_byte[7]}}, w_byte};
                w_be    = 4'b0001 << addr_q[1:0];
                w_wlane = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                w_legal = !addr_q[0];
                w_load  = {{16{w_half[15]}}, w_half};
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                w_legal = (addr_q[1:0] == 2'b00);
                w_load  = w_word;
                w_be    = 4'b1111;
            end
            3'b100: begin
                w_legal = !write_q;
                w_load  = {24'd0, w_byte};
            end
            3'b101: begin
                w_legal = !write_q && !addr_q[0];
                w_load  = {16'd0, w_half};
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_mem_we = (state_q == S_ACCESS) && w_legal && write_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                rdata_d = (w_legal && !write_q) ? w_load : 32'd0;
                error_d = !w_legal;
                if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = C_WAIT_LOAD;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    error_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (w_accept) begin
                write_q <= req_write;
                addr_q  <= req_addr[ADDR_WIDTH+1:0];
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
        end
    end

    // Array is intentionally not reset; only the lanes selected by w_be change.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) mem_q[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// Module   : tb_data_memory_responder
// Brief    : Directed + randomized bench for data_memory_responder, two
//            instances (WAIT_CYCLES=1 and WAIT_CYCLES=0) against a byte model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

    localparam int AW    = 10;
    localparam int BYTES = 4 * (2**AW);

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    int          sel;

    logic        v0, v1;
    logic        rr0, rr1, rv0, rv1, re0, re1;
    logic [31:0] rd0, rd1;
    logic        o_rr, o_rv, o_re;
    logic [31:0] o_rd;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [2][BYTES];

    assign v0   = req_valid && (sel == 0);
    assign v1   = req_valid && (sel == 1);
    assign o_rr = (sel == 1) ? rr1 : rr0;
    assign o_rv = (sel == 1) ? rv1 : rv0;
    assign o_re = (sel == 1) ? re1 : re0;
    assign o_rd = (sel == 1) ? rd1 : rd0;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rr0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .resp_valid(rv0), .resp_ready(resp_ready),
        .resp_rdata(rd0), .resp_error(re0));

    data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rr1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .resp_valid(rv1), .resp_ready(resp_ready),
        .resp_rdata(rd1), .resp_error(re1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-addressed little-endian memory, RISC-V rules.
    function automatic void model(input int d, input logic w, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output logic [31:0] rd, output logic err);
        int size, base;
        logic legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        legal = legal && ((a % size) == 0);
        base  = int'(a % BYTES);
        rd    = 32'd0;
        err   = !legal;
        if (legal) begin
            if (w) begin
                for (int i = 0; i < size; i++) mb[d][base + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mb[d][base + i]) << (8 * i));
                if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endfunction

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
        int n = 0;
        req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
        while (!o_rr && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int lat);
        int k = 0;
        while (!o_rv && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(lat));
    endtask

    task automatic finish_resp(input logic [31:0] erd, input logic eerr, input int hold);
        chk("rdata", o_rd, erd);
        chk("error", 32'(o_re), 32'(eerr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(o_rv), 32'd1);
            chk("hold_rdata", o_rd, erd);
            chk("hold_ready", 32'(o_rr), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_valid", 32'(o_rv), 32'd0);
        chk("post_rdata", o_rd, 32'd0);
        chk("post_ready", 32'(o_rr), 32'd1);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input int hold, output logic [31:0] got);
        logic [31:0] erd;
        logic eerr;
        model(sel, w, a, wd, f3, erd, eerr);
        issue(w, a, wd, f3);
        wait_resp(sel == 1 ? 2 : 1);
        got = o_rd;
        finish_resp(erd, eerr, hold);
    endtask

    initial begin
        logic [31:0] got, erd;
        logic        eerr;

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0; sel = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_ready1", 32'(rr1), 32'd0);
        chk("rst_ready0", 32'(rr0), 32'd0);
        chk("rst_valid1", 32'(rv1), 32'd0);
        chk("rst_rdata1", rd1, 32'd0);
        chk("rst_error1", 32'(re1), 32'd0);
        rst = 1'b1;
        #1 chk("ready_after_rst", 32'(rr1), 32'd1);
        @(negedge clk);

        // Word round trip and lanes on the WAIT_CYCLES=1 instance.
        txn(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, got);
        txn(1'b0, 32'h100, 32'd0, 3'b010, 0, got);
        chk("lw_deadbeef", got, 32'hDEADBEEF);
        txn(1'b1, 32'h101, 32'h0000_0080, 3'b000, 0, got);
        txn(1'b0, 32'h101, 32'd0, 3'b000, 0, got);
        chk("lb_sext", got, 32'hFFFF_FF80);
        txn(1'b0, 32'h101, 32'd0, 3'b100, 0, got);
        chk("lbu_zext", got, 32'h0000_0080);
        txn(1'b1, 32'h102, 32'h0000_1234, 3'b001, 0, got);
        txn(1'b0, 32'h100, 32'd0, 3'b010, 0, got);
        chk("lw_lanes", got, 32'h123480EF);

        // Misaligned and illegal accesses.
        txn(1'b1, 32'h102, 32'h5555_5555, 3'b010, 0, got);
        txn(1'b0, 32'h100, 32'd0, 3'b010, 0, got);
        chk("lw_unchanged", got, 32'h123480EF);
        txn(1'b0, 32'h101, 32'd0, 3'b001, 0, got);
        txn(1'b0, 32'h100, 32'd0, 3'b011, 0, got);
        txn(1'b1, 32'h100, 32'd0, 3'b100, 0, got);

        // Reset while a load sits in WAIT.
        issue(1'b0, 32'h100, 32'd0, 3'b010);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_rv), 32'd0);
        chk("midrst_rdata", o_rd, 32'd0);
        chk("midrst_ready", 32'(o_rr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_release", 32'(o_rr), 32'd1);
        @(negedge clk);
        txn(1'b0, 32'h100, 32'd0, 3'b010, 0, got);

        // Store dropped by reset while in ACCESS must leave the array untouched.
        txn(1'b1, 32'h104, 32'hA5A5_0001, 3'b010, 0, got);
        issue(1'b1, 32'h104, 32'hFFFF_FFFF, 3'b010);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h104, 32'd0, 3'b010, 0, got);
        chk("dropped_store", got, 32'hA5A5_0001);

        // Backpressure with a queued request held valid.
        model(1, 1'b0, 32'h100, 32'd0, 3'b010, erd, eerr);
        issue(1'b0, 32'h100, 32'd0, 3'b010);
        wait_resp(2);
        req_write = 1'b0; req_addr = 32'h101; req_funct3 = 3'b100; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(o_rv), 32'd1);
            chk("bp_rdata", o_rd, erd);
            chk("bp_error", 32'(o_re), 32'(eerr));
            chk("bp_ready", 32'(o_rr), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_drop", 32'(o_rv), 32'd0);
        chk("bp_idle_ready", 32'(o_rr), 32'd1);
        model(1, 1'b0, 32'h101, 32'd0, 3'b100, erd, eerr);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_accepted", 32'(o_rr), 32'd0);
        wait_resp(2);
        finish_resp(erd, eerr, 0);

        // Randomized traffic on the WAIT_CYCLES=1 instance.
        for (int i = 0; i < 16; i++) txn(1'b1, 32'h200 + 32'(4*i), $urandom, 3'b010, 0, got);
        for (int i = 0; i < 30; i++)
            txn(1'($urandom % 2), (32'h200 + ($urandom % 64)) | (32'($urandom_range(0, 3)) << 12),
                $urandom, 3'($urandom % 8), int'($urandom % 3), got);

        // WAIT_CYCLES=0 instance: aliasing, latency, random traffic.
        sel = 0;
        @(negedge clk);
        txn(1'b1, 32'h0, 32'hCAFE_F00D, 3'b010, 0, got);
        txn(1'b0, 32'(4 * (2**AW)), 32'd0, 3'b010, 0, got);
        chk("alias", got, 32'hCAFE_F00D);
        for (int i = 0; i < 16; i++) txn(1'b1, 32'h300 + 32'(4*i), $urandom, 3'b010, 0, got);
        for (int i = 0; i < 30; i++)
            txn(1'($urandom % 2), (32'h300 + ($urandom % 64)) | (32'($urandom_range(0, 3)) << 12),
                $urandom, 3'($urandom % 8), int'($urandom % 3), got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
